// File: rtl/mem_arbiter_if.sv
// Request-unit and memory-bus signal bundle for the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/bus-model view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imemRen;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmmRen;
  logic              dmmWen;
  logic [ADDR_W-1:0] dmmaddr;
  logic [DATA_W-1:0] dmmstore;
  logic              i_ready;
  logic [DATA_W-1:0] imemload;
  logic              d_ready;
  logic [DATA_W-1:0] dmmload;
  logic              bus_ren;
  logic              bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              timeout_err;

  modport slave (
    input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, bus_rdata, bus_ack,
    output i_ready, imemload, d_ready, dmmload, bus_ren, bus_wen, bus_addr, bus_wdata,
           timeout_err
  );

  modport master (
    output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, bus_rdata, bus_ack,
    input  i_ready, imemload, d_ready, dmmload, bus_ren, bus_wen, bus_addr, bus_wdata,
           timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one word-wide bus (data wins),
// returns one-cycle ready pulses and aborts stalled accesses via a watchdog.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic       CLK,
  input logic       nRST,
  mem_arbiter_if.slave mif
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

  state_t            state_reg, state_next;
  kind_t             kind_reg, kind_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] load_reg, load_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              terr_reg, terr_next;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= IDLE;
      kind_reg  <= K_FETCH;
      addr_reg  <= '0;
      wdata_reg <= '0;
      load_reg  <= '0;
      cnt_reg   <= '0;
      terr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kind_reg  <= kind_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      load_reg  <= load_next;
      cnt_reg   <= cnt_next;
      terr_reg  <= terr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    load_next  = load_reg;
    cnt_next   = cnt_reg;
    terr_next  = terr_reg;
    case (state_reg)
      IDLE: begin
        wdata_next = mif.dmmstore;
        if (mif.dmmWen) begin
          kind_next  = K_WRITE;
          addr_next  = mif.dmmaddr & ALIGN_MASK;
          state_next = BUS;
        end else if (mif.dmmRen) begin
          kind_next  = K_READ;
          addr_next  = mif.dmmaddr & ALIGN_MASK;
          state_next = BUS;
        end else if (mif.imemRen) begin
          kind_next  = K_FETCH;
          addr_next  = mif.imemaddr & ALIGN_MASK;
          state_next = BUS;
        end
      end
      BUS: begin
        // An ack on the final watchdog cycle still completes normally.
        if (mif.bus_ack) begin
          load_next  = (kind_reg == K_WRITE) ? '0 : mif.bus_rdata;
          cnt_next   = '0;
          state_next = DONE;
        end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
          load_next  = '0;
          terr_next  = 1'b1;
          cnt_next   = '0;
          state_next = DONE;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  logic in_bus, in_done, is_write;
  assign in_bus   = (state_reg == BUS);
  assign in_done  = (state_reg == DONE);
  assign is_write = (kind_reg == K_WRITE);

  assign mif.bus_ren     = in_bus && !is_write;
  assign mif.bus_wen     = in_bus && is_write;
  assign mif.bus_addr    = in_bus ? addr_reg : '0;
  assign mif.bus_wdata   = (in_bus && is_write) ? wdata_reg : '0;
  assign mif.i_ready     = in_done && (kind_reg == K_FETCH);
  assign mif.d_ready     = in_done && (kind_reg != K_FETCH);
  assign mif.imemload    = (in_done && (kind_reg == K_FETCH)) ? load_reg : '0;
  assign mif.dmmload     = (in_done && (kind_reg == K_READ)) ? load_reg : '0;
  assign mif.timeout_err = terr_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: each episode predicts the cycle-by-cycle outputs of one
// request from the arbitration rules, plus literal checks for the directed cases.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .mif (mif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // expected outputs for the current cycle
  logic        e_iready, e_dready, e_ren, e_wen, e_terr;
  logic [31:0] e_iload, e_dload, e_addr, e_wdata;
  logic        model_terr = 1'b0;

  // observations for the literal checks of one episode
  int          obs_ren, obs_wen, obs_iready, obs_dready;
  logic [31:0] obs_iload, obs_dload, obs_addr, obs_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    chk("i_ready",     {31'b0, mif.i_ready},     {31'b0, e_iready});
    chk("imemload",    mif.imemload,             e_iload);
    chk("d_ready",     {31'b0, mif.d_ready},     {31'b0, e_dready});
    chk("dmmload",     mif.dmmload,              e_dload);
    chk("bus_ren",     {31'b0, mif.bus_ren},     {31'b0, e_ren});
    chk("bus_wen",     {31'b0, mif.bus_wen},     {31'b0, e_wen});
    chk("bus_addr",    mif.bus_addr,             e_addr);
    chk("bus_wdata",   mif.bus_wdata,            e_wdata);
    chk("timeout_err", {31'b0, mif.timeout_err}, {31'b0, e_terr});
    if (mif.bus_ren === 1'b1) begin obs_ren++; obs_addr = mif.bus_addr; end
    if (mif.bus_wen === 1'b1) begin obs_wen++; obs_wdata = mif.bus_wdata; obs_addr = mif.bus_addr; end
    if (mif.i_ready === 1'b1) begin obs_iready++; obs_iload = mif.imemload; end
    if (mif.d_ready === 1'b1) begin obs_dready++; obs_dload = mif.dmmload; end
  endtask

  task automatic step();
    @(negedge CLK);
    check_cycle();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_idle_exp();
    e_iready = 1'b0; e_dready = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
    e_iload = '0; e_dload = '0; e_addr = '0; e_wdata = '0;
    e_terr = model_terr;
  endtask

  task automatic clear_obs();
    obs_ren = 0; obs_wen = 0; obs_iready = 0; obs_dready = 0;
    obs_iload = '0; obs_dload = '0; obs_addr = '0; obs_wdata = '0;
  endtask

  task automatic drive_req(input logic ir, input logic dr, input logic dw,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] st);
    mif.imemRen = ir; mif.dmmRen = dr; mif.dmmWen = dw;
    mif.imemaddr = ia; mif.dmmaddr = da; mif.dmmstore = st;
  endtask

  // One request from IDLE: k = BUS cycles before ack (k >= TO never acks).
  task automatic episode(input logic ir, input logic dr, input logic dw,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] st,
                         input int k, input logic [31:0] rd, input bit drop, input bit noise);
    int          kind;
    logic [31:0] a;
    bit          timed;
    int          nb;
    clear_obs();
    drive_req(ir, dr, dw, ia, da, st);
    mif.bus_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mif.bus_rdata = $urandom;
    set_idle_exp();
    step();
    if (dw) kind = 3;
    else if (dr) kind = 2;
    else if (ir) kind = 1;
    else return;
    a     = ((kind == 1) ? ia : da) & 32'hFFFF_FFFC;
    timed = (k >= TO);
    nb    = timed ? TO : k + 1;
    for (int c = 0; c < nb; c++) begin
      if (drop)
        drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom);
      mif.bus_ack   = (!timed && c == k);
      mif.bus_rdata = mif.bus_ack ? rd : $urandom;
      set_idle_exp();
      e_ren   = (kind != 3);
      e_wen   = (kind == 3);
      e_addr  = a;
      e_wdata = (kind == 3) ? st : 32'h0;
      step();
    end
    if (timed) model_terr = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
    mif.bus_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mif.bus_rdata = $urandom;
    set_idle_exp();
    e_iready = (kind == 1);
    e_dready = (kind >= 2);
    e_iload  = (kind == 1 && !timed) ? rd : 32'h0;
    e_dload  = (kind == 2 && !timed) ? rd : 32'h0;
    step();
  endtask

  initial begin
    nRST = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    mif.bus_ack = 1'b0; mif.bus_rdata = '0;
    clear_obs();
    @(posedge CLK);
    #1;
    set_idle_exp();
    step();
    nRST = 1'b1;
    step();

    // fetch only, ack on 2nd BUS cycle
    episode(1, 0, 0, 32'h0000_1006, 32'h0, 32'h0, 1, 32'h0051_0113, 0, 0);
    chk("lit_fetch_ren_cycles", obs_ren, 2);
    chk("lit_fetch_addr", obs_addr, 32'h0000_1004);
    chk("lit_fetch_iload", obs_iload, 32'h0051_0113);
    chk("lit_fetch_dready", obs_dready, 0);

    // simultaneous fetch and data read: data first
    episode(1, 1, 0, 32'h0000_0040, 32'h0000_0200, 32'h0, 0, 32'hAAAA_5555, 0, 0);
    chk("lit_sim_dready", obs_dready, 1);
    chk("lit_sim_dload", obs_dload, 32'hAAAA_5555);
    chk("lit_sim_iready", obs_iready, 0);
    episode(1, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 0, 32'h1234_5678, 0, 0);
    chk("lit_sim_iload", obs_iload, 32'h1234_5678);
    chk("lit_sim_iready2", obs_iready, 1);

    // write
    episode(0, 0, 1, 32'h0, 32'h0000_0300, 32'hDEAD_BEEF, 0, 32'h5555_5555, 0, 0);
    chk("lit_wr_wen_cycles", obs_wen, 1);
    chk("lit_wr_wdata", obs_wdata, 32'hDEAD_BEEF);
    chk("lit_wr_ren_cycles", obs_ren, 0);
    chk("lit_wr_dload", obs_dload, 32'h0);

    // request dropped mid-flight, ack after 3 waits
    episode(0, 1, 0, 32'h0, 32'h0000_0400, 32'h0, 3, 32'h0BAD_F00D, 1, 0);
    chk("lit_drop_dready", obs_dready, 1);
    chk("lit_drop_ren_cycles", obs_ren, 4);
    chk("lit_drop_dload", obs_dload, 32'h0BAD_F00D);

    // watchdog abort, then a successful fetch keeps the sticky flag
    episode(1, 0, 0, 32'h0000_0800, 32'h0, 32'h0, 100, 32'h0, 0, 0);
    chk("lit_to_ren_cycles", obs_ren, 4);
    chk("lit_to_iready", obs_iready, 1);
    chk("lit_to_iload", obs_iload, 32'h0);
    chk("lit_to_err", {31'b0, mif.timeout_err}, 32'h1);
    episode(1, 0, 0, 32'h0000_0804, 32'h0, 32'h0, 0, 32'h0000_0013, 0, 0);
    chk("lit_to_err_sticky", {31'b0, mif.timeout_err}, 32'h1);

    // reset during BUS aborts silently and clears the flag
    clear_obs();
    drive_req(1'b0, 1'b1, 1'b0, '0, 32'h0000_0500, '0);
    mif.bus_ack = 1'b0;
    set_idle_exp();
    step();
    nRST = 1'b0;
    set_idle_exp();
    e_ren = 1'b1; e_addr = 32'h0000_0500;
    step();
    nRST = 1'b1;
    model_terr = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_idle_exp();
    step();
    step();
    chk("lit_rst_dready", obs_dready, 0);
    chk("lit_rst_err", {31'b0, mif.timeout_err}, 32'h0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      episode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              $urandom, $urandom, $urandom, int'($urandom_range(0, 5)), $urandom,
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the CPU memory request interface.
- Accepts level-held instruction-fetch and data read/write requests from the request unit and arbitrates them onto a single word-wide memory bus.
- Returns one-cycle ready pulses with load data.
- Sits between the request unit and the SRAM/bus wrapper; includes a bus-ack timeout watchdog.

Parameters:
- ADDR_W, 32, width of request and bus addresses.
- DATA_W, 32, width of load/store data.
- TIMEOUT, 64, cycles in BUS state without bus_ack before abort; 0 disables the watchdog.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset.
- imemRen  input  1  instruction fetch request (level, held until i_ready).
- imemaddr  input  ADDR_W  fetch address.
- dmmRen  input  1  data read request (level).
- dmmWen  input  1  data write request (level).
- dmmaddr  input  ADDR_W  data address.
- dmmstore  input  DATA_W  store data.
- i_ready  output  1  one-cycle pulse: fetch complete.
- imemload  output  DATA_W  fetched instruction; valid while i_ready=1.
- d_ready  output  1  one-cycle pulse: data access complete.
- dmmload  output  DATA_W  load data; valid while d_ready=1.
- bus_ren  output  1  bus read strobe.
- bus_wen  output  1  bus write strobe.
- bus_addr  output  ADDR_W  bus address, word aligned.
- bus_wdata  output  DATA_W  bus write data.
- bus_rdata  input  DATA_W  bus read data, valid with bus_ack.
- bus_ack  input  1  bus completion, one cycle.
- timeout_err  output  1  sticky flag: a transaction was aborted by the watchdog.

Behaviour:
- Reset (CLK edge with nRST=0): state=IDLE, wait counter=0, latched regs=0; all outputs 0, including timeout_err. A reset mid-transaction aborts it silently, with no ready pulse.
- States: IDLE, BUS, DONE.
- IDLE:
  - Sample requests. Priority is data over instruction.
  - dmmWen=1 → write transaction. dmmWen and dmmRen both 1 is treated as a write.
  - Else dmmRen=1 → data read.
  - Else imemRen=1 → fetch.
  - On any accepted request: latch kind, address {addr[ADDR_W-1:2],2'b00} and store data; next state BUS. With no request, stay in IDLE.
- BUS:
  - Drive bus_ren/bus_wen, bus_addr and bus_wdata from the latched regs only, stable for the whole state.
  - Requester inputs are ignored: dropping or changing a request mid-transaction has no effect, and the transaction still completes and pulses ready.
  - Wait counter increments each cycle without bus_ack.
  - bus_ack=1 → capture bus_rdata (reads only) into the load register; counter=0; next state DONE.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 with no ack → load register=0, timeout_err←1; next state DONE.
- DONE:
  - Strobes low.
  - Exactly one of i_ready/d_ready high for one cycle, matching the latched kind. Writes pulse d_ready.
  - Matching load output shows the load register; writes present dmmload=0.
  - Next state IDLE unconditionally.
- Load outputs: driven from the load register only while the matching ready is high, 0 otherwise.
- Latency: request seen in IDLE at cycle N → BUS from N+1; ack at N+1+k (k≥0) → ready at N+2+k → IDLE at N+3+k. Minimum request-to-ready is 2 cycles.
- The mandatory IDLE cycle after DONE lets the requester update its registered request lines before the next sample. Back-to-back transactions are spaced 3+k cycles apart.
- Starvation: a continuously asserted data request blocks fetch. This is accepted, because the data request is dropped after d_ready in normal pipeline operation.
- bus_ack outside BUS is ignored.
- Counter width is sized for TIMEOUT-1 and never wraps.
- timeout_err clears only on reset.

Test Plan:
- Fetch only: imemRen=1, imemaddr=0x0000_1006, bus_ack at 2nd BUS cycle with bus_rdata=0x0051_0113 → bus_addr=0x0000_1004, bus_ren=1 for 2 cycles, i_ready pulse with imemload=0x0051_0113 at N+3, d_ready stays 0.
- Simultaneous: imemRen=1 and dmmRen=1 (dmmaddr=0x200) in the same cycle, immediate acks, rdata 0xAAAA_5555 then 0x1234_5678 → data read first with d_ready/dmmload=0xAAAA_5555, then fetch with i_ready/imemload=0x1234_5678; each ready is a single cycle.
- Write: dmmWen=1, dmmaddr=0x300, dmmstore=0xDEAD_BEEF, ack after 0 cycles → bus_wen=1, bus_wdata=0xDEAD_BEEF for 1 cycle, d_ready pulse with dmmload=0, bus_ren never 1.
- Drop mid-flight: dmmRen deasserted in the first BUS cycle, ack 3 cycles later → bus_addr unchanged throughout; d_ready still pulses once.
- Timeout with TIMEOUT=4: fetch, never ack → bus_ren high for exactly 4 cycles, i_ready pulse with imemload=0, timeout_err=1 and still 1 after the next successful transaction.
- Reset in BUS: nRST=0 for one edge during a read → next cycle all strobes 0, no ready pulse, state IDLE, timeout_err=0.
